useq_next_addr: RTL

//   Micro-sequencer next-address generator; sits directly upstream of the micro-PC register.

---
 rtl/useq_next_addr.sv | 155 +++++++++++++++
 1 files changed

// File: rtl/useq_next_addr.sv
// ---------------------------------------------------------------------------
// useq_next_addr
//   Micro-sequencer next-address generator. It decodes the sequencing field
//   of the current microword and produces the load target and load strobe
//   for the micro-PC register. It also provides conditional branch, opcode
//   dispatch (map) and a small call/return stack.
//
//   Handshake: there is no valid/ready pair. upc_next/load_incr are valid
//   every cycle and are combinational from the inputs and the stack top.
//   The micro-PC register captures them on the same rising edge that commits
//   any stack push or pop.
//
// Ports
//   clk        rising-edge clock shared with the micro-PC register
//   reset_n    asynchronous active-low reset (empties stack, clears error)
//   upc        current micro-PC
//   seq_op     000 CONT, 001 JUMP, 010 CJMP, 011 CALL, 100 RET, 101 MAP,
//              11x behaves as CONT
//   br_addr    branch/call target from the microword
//   map_addr   dispatch target from instruction decode
//   cond_in    datapath status flags
//   cond_sel   selects the condition bit used by CJMP
//   cond_pol   1 = branch when the selected bit is 0
//   stall      freeze sequencing: micro-PC reloads itself, stack untouched
//   upc_next   load target for the micro-PC register
//   load_incr  1 = load upc_next, 0 = micro-PC increments
//   stk_depth  number of valid return-stack entries
//   stk_err    sticky overflow/underflow flag, cleared only by reset
// ---------------------------------------------------------------------------
module useq_next_addr #(
   parameter int AW    = 5,
   parameter int DEPTH = 4,
   parameter int NCOND = 4,
   localparam int CSW  = (NCOND > 1) ? $clog2(NCOND) : 1,
   localparam int DW   = $clog2(DEPTH) + 1,
   localparam int IW   = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic [AW-1:0]    upc,
   input  logic [2:0]       seq_op,
   input  logic [AW-1:0]    br_addr,
   input  logic [AW-1:0]    map_addr,
   input  logic [NCOND-1:0] cond_in,
   input  logic [CSW-1:0]   cond_sel,
   input  logic             cond_pol,
   input  logic             stall,
   output logic [AW-1:0]    upc_next,
   output logic             load_incr,
   output logic [DW-1:0]    stk_depth,
   output logic             stk_err
);

   localparam logic [2:0] OP_CONT = 3'b000;
   localparam logic [2:0] OP_JUMP = 3'b001;
   localparam logic [2:0] OP_CJMP = 3'b010;
   localparam logic [2:0] OP_CALL = 3'b011;
   localparam logic [2:0] OP_RET  = 3'b100;
   localparam logic [2:0] OP_MAP  = 3'b101;

   logic [AW-1:0] r_stack [DEPTH];
   logic [DW-1:0] r_sp;
   logic          r_err;

   logic          w_cond;
   logic          w_full;
   logic          w_empty;
   logic          w_push;
   logic          w_pop;
   logic          w_err;
   logic [IW-1:0] w_push_idx;
   logic [IW-1:0] w_top_idx;
   logic [AW-1:0] w_ret_addr;

   assign w_cond     = cond_in[cond_sel] ^ cond_pol;
   assign w_full     = (r_sp == DW'(DEPTH));
   assign w_empty    = (r_sp == '0);
   // r_sp points at the next free slot; the top entry sits one below it.
   assign w_push_idx = IW'(r_sp);
   assign w_top_idx  = IW'(r_sp - DW'(1));
   // Return address wraps naturally at 2^AW.
   assign w_ret_addr = upc + AW'(1);

   always_comb begin
      upc_next  = '0;
      load_incr = 1'b0;
      w_push    = 1'b0;
      w_pop     = 1'b0;
      w_err     = 1'b0;
      if (stall) begin
         // Reload the current address so the micro-PC holds.
         upc_next  = upc;
         load_incr = 1'b1;
      end else begin
         case (seq_op)
            OP_JUMP: begin
               upc_next  = br_addr;
               load_incr = 1'b1;
            end
            OP_CJMP: begin
               if (w_cond) begin
                  upc_next  = br_addr;
                  load_incr = 1'b1;
               end
            end
            OP_CALL: begin
               // The jump is taken even when the push has to be dropped.
               upc_next  = br_addr;
               load_incr = 1'b1;
               if (w_full) w_err  = 1'b1;
               else        w_push = 1'b1;
            end
            OP_RET: begin
               // Underflow falls through to the next sequential address.
               if (w_empty) begin
                  w_err = 1'b1;
               end else begin
                  upc_next  = r_stack[w_top_idx];
                  load_incr = 1'b1;
                  w_pop     = 1'b1;
               end
            end
            OP_MAP: begin
               upc_next  = map_addr;
               load_incr = 1'b1;
            end
            default: begin
               // CONT and the unused 11x codes: increment.
               upc_next  = '0;
               load_incr = 1'b0;
            end
         endcase
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_sp  <= '0;
         r_err <= 1'b0;
      end else begin
         if (w_push)     r_sp <= r_sp + DW'(1);
         else if (w_pop) r_sp <= r_sp - DW'(1);
         if (w_err)      r_err <= 1'b1;
      end
   end

   // Stack storage needs no reset: an empty pointer makes every entry dead.
   always_ff @(posedge clk) begin
      if (w_push) r_stack[w_push_idx] <= w_ret_addr;
   end

   assign stk_depth = r_sp;
   assign stk_err   = r_err;

endmodule
